// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, byte-addressed little-endian
// data memory, W pipeline register and the sticky halt flag.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_valid,
  input  logic [3:0]  e_icode,
  input  logic        e_cond,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [63:0] e_valP,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic [1:0]  e_stat,
  input  logic        m_stall,
  input  logic        m_bubble,
  output logic        w_valid,
  output logic [3:0]  w_icode,
  output logic [63:0] w_valE,
  output logic [63:0] w_valM,
  output logic [3:0]  w_dstE,
  output logic [3:0]  w_dstM,
  output logic [1:0]  w_stat,
  output logic        halted
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_ADR = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    logic        cond;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [63:0] val_p;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [1:0]  stat;
  } m_reg_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [1:0]  stat;
  } w_reg_t;

  localparam m_reg_t M_BUBBLE = '{valid: 1'b0, icode: I_NOP, cond: 1'b0,
                                  val_e: 64'd0, val_a: 64'd0, val_p: 64'd0,
                                  dst_e: R_NONE, dst_m: R_NONE, stat: S_AOK};
  localparam w_reg_t W_BUBBLE = '{valid: 1'b0, icode: I_NOP, val_e: 64'd0,
                                  val_m: 64'd0, dst_e: R_NONE, dst_m: R_NONE,
                                  stat: S_AOK};

  m_reg_t m_q, m_d;
  w_reg_t w_q, w_d;
  logic   halted_q, halted_d;

  logic [7:0]    mem [MEM_BYTES];
  logic          is_read, is_write, adr_err, mem_we;
  logic [63:0]   mem_addr, rdata, wdata, val_m;
  logic [AW-1:0] mem_idx;
  logic [1:0]    final_stat;

  // Next M register: stall holds, bubble clears, otherwise take execute's result
  always_comb begin
    m_d = m_q;
    if (m_stall) begin
      m_d = m_q;
    end else if (m_bubble) begin
      m_d = M_BUBBLE;
    end else begin
      m_d = '{valid: e_valid, icode: e_icode, cond: e_cond, val_e: e_valE,
              val_a: e_valA, val_p: e_valP, dst_e: e_dstE, dst_m: e_dstM,
              stat: e_stat};
    end
  end

  // Decode the memory operation of the M instruction and check its address
  always_comb begin
    is_read  = (m_q.icode == I_MRMOV) || (m_q.icode == I_POP) || (m_q.icode == I_RET);
    is_write = (m_q.icode == I_RMMOV) || (m_q.icode == I_PUSH) || (m_q.icode == I_CALL);
    mem_addr = ((m_q.icode == I_POP) || (m_q.icode == I_RET)) ? m_q.val_a : m_q.val_e;
    mem_idx  = mem_addr[AW-1:0];
    adr_err  = m_q.valid && (is_read || is_write) && (mem_addr > MAX_ADDR);
    wdata    = (m_q.icode == I_CALL) ? m_q.val_p : m_q.val_a;
    mem_we   = m_q.valid && is_write && !adr_err && !m_stall &&
               (m_q.stat == S_AOK) && !halted_q;
    final_stat = adr_err ? S_ADR : m_q.stat;
  end

  // Little-endian 8-byte read; zero for anything that does not read memory
  always_comb begin
    rdata = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[mem_idx + AW'(i)];
    end
    val_m = (m_q.valid && is_read && !adr_err) ? rdata : 64'd0;
  end

  // Next W register and halt flag; stalls and a halted pipeline insert bubbles
  always_comb begin
    w_d = W_BUBBLE;
    if (!m_stall && !halted_q) begin
      w_d.valid = m_q.valid;
      w_d.icode = m_q.icode;
      w_d.val_e = m_q.val_e;
      w_d.val_m = val_m;
      w_d.dst_e = ((m_q.icode == I_CMOV) && !m_q.cond) ? R_NONE : m_q.dst_e;
      w_d.dst_m = m_q.dst_m;
      w_d.stat  = final_stat;
    end
    halted_d = halted_q || (w_d.valid && (w_d.stat != S_AOK));
  end

  // Pipeline registers and sticky halt flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q      <= M_BUBBLE;
      w_q      <= W_BUBBLE;
      halted_q <= 1'b0;
    end else begin
      m_q      <= m_d;
      w_q      <= w_d;
      halted_q <= halted_d;
    end
  end

  // Data memory commit; contents survive reset but reset blocks the write
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < 8; i++) begin
        mem[mem_idx + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  assign w_valid = w_q.valid;
  assign w_icode = w_q.icode;
  assign w_valE  = w_q.val_e;
  assign w_valM  = w_q.val_m;
  assign w_dstE  = w_q.dst_e;
  assign w_dstM  = w_q.dst_m;
  assign w_stat  = w_q.stat;
  assign halted  = halted_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected W results are queued when an
// instruction is issued and compared when the DUT shows a valid W entry.
module tb_memory_stage;

  logic        clk, rst;
  logic        e_valid, e_cond, m_stall, m_bubble;
  logic [3:0]  e_icode, e_dstE, e_dstM;
  logic [63:0] e_valE, e_valA, e_valP;
  logic [1:0]  e_stat;
  logic        w_valid, halted;
  logic [3:0]  w_icode, w_dstE, w_dstM;
  logic [63:0] w_valE, w_valM;
  logic [1:0]  w_stat;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [1:0]  stat;
  } exp_t;

  exp_t sb[$];
  int   total_checks = 0;
  int   passed_checks = 0;

  memory_stage #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .e_valid(e_valid), .e_icode(e_icode), .e_cond(e_cond),
    .e_valE(e_valE), .e_valA(e_valA), .e_valP(e_valP),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .e_stat(e_stat),
    .m_stall(m_stall), .m_bubble(m_bubble),
    .w_valid(w_valid), .w_icode(w_icode), .w_valE(w_valE), .w_valM(w_valM),
    .w_dstE(w_dstE), .w_dstM(w_dstM), .w_stat(w_stat), .halted(halted)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total_checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    else
      passed_checks++;
  endtask

  // Drive one real AOK instruction onto the execute outputs
  task automatic applyStimulus(input logic [3:0] icode, input logic cond,
                               input logic [63:0] val_e, input logic [63:0] val_a,
                               input logic [63:0] val_p, input logic [3:0] dst_e,
                               input logic [3:0] dst_m);
    e_valid = 1'b1; e_icode = icode; e_cond = cond;
    e_valE = val_e; e_valA = val_a; e_valP = val_p;
    e_dstE = dst_e; e_dstM = dst_m; e_stat = 2'd0;
  endtask

  // Drive an empty execute slot
  task automatic applyIdle();
    e_valid = 1'b0; e_icode = 4'h1; e_cond = 1'b0;
    e_valE = '0; e_valA = '0; e_valP = '0;
    e_dstE = 4'hF; e_dstM = 4'hF; e_stat = 2'd0;
  endtask

  task automatic pushExpected(input logic [3:0] icode, input logic [63:0] val_e,
                              input logic [63:0] val_m, input logic [3:0] dst_e,
                              input logic [3:0] dst_m, input logic [1:0] stat);
    exp_t e;
    e.icode = icode; e.val_e = val_e; e.val_m = val_m;
    e.dst_e = dst_e; e.dst_m = dst_m; e.stat = stat;
    sb.push_back(e);
  endtask

  // Advance one clock and compare any valid W entry against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (w_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_w_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("w_icode", 64'(w_icode), 64'(e.icode));
        checkOutput("w_valE",  w_valE, e.val_e);
        checkOutput("w_valM",  w_valM, e.val_m);
        checkOutput("w_dstE",  64'(w_dstE), 64'(e.dst_e));
        checkOutput("w_dstM",  64'(w_dstM), 64'(e.dst_m));
        checkOutput("w_stat",  64'(w_stat), 64'(e.stat));
      end
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"},  64'(w_valid), 64'd0);
    checkOutput({tag, "_icode"},  64'(w_icode), 64'h1);
    checkOutput({tag, "_valE"},   w_valE, 64'd0);
    checkOutput({tag, "_valM"},   w_valM, 64'd0);
    checkOutput({tag, "_dstE"},   64'(w_dstE), 64'hF);
    checkOutput({tag, "_dstM"},   64'(w_dstM), 64'hF);
    checkOutput({tag, "_stat"},   64'(w_stat), 64'd0);
    checkOutput({tag, "_halted"}, 64'(halted), 64'd0);
  endtask

  // Main stimulus sequence
  initial begin
    rst = 1'b1; m_stall = 1'b0; m_bubble = 1'b0;
    applyIdle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkResetState("reset");

    // Store two quadwords, read one back and read an unaligned window across both
    applyStimulus(4'h4, 0, 64'h100, 64'h1122334455667788, 0, 4'hF, 4'hF);
    pushExpected(4'h4, 64'h100, 0, 4'hF, 4'hF, 0); tick();
    applyStimulus(4'h4, 0, 64'h108, 64'hAABBCCDDEEFF0099, 0, 4'hF, 4'hF);
    pushExpected(4'h4, 64'h108, 0, 4'hF, 4'hF, 0); tick();
    applyStimulus(4'h5, 0, 64'h100, 0, 0, 4'hF, 4'h3);
    pushExpected(4'h5, 64'h100, 64'h1122334455667788, 4'hF, 4'h3, 0); tick();
    applyStimulus(4'h5, 0, 64'h101, 0, 0, 4'hF, 4'h3);
    pushExpected(4'h5, 64'h101, 64'h9911223344556677, 4'hF, 4'h3, 0); tick();

    // call/ret at the last legal address, then push/pop
    applyStimulus(4'h8, 0, 64'h3F8, 0, 64'h40, 4'h4, 4'hF);
    pushExpected(4'h8, 64'h3F8, 0, 4'h4, 4'hF, 0); tick();
    applyStimulus(4'h9, 0, 64'h400, 64'h3F8, 0, 4'h4, 4'hF);
    pushExpected(4'h9, 64'h400, 64'h40, 4'h4, 4'hF, 0); tick();
    applyStimulus(4'hA, 0, 64'h3F0, 64'hDEADBEEFCAFEF00D, 0, 4'h4, 4'hF);
    pushExpected(4'hA, 64'h3F0, 0, 4'h4, 4'hF, 0); tick();
    applyStimulus(4'hB, 0, 64'h3F8, 64'h3F0, 0, 4'h4, 4'h2);
    pushExpected(4'hB, 64'h3F8, 64'hDEADBEEFCAFEF00D, 4'h4, 4'h2, 0); tick();

    // Conditional move, not taken then taken
    applyStimulus(4'h2, 0, 64'h55, 0, 0, 4'h5, 4'hF);
    pushExpected(4'h2, 64'h55, 0, 4'hF, 4'hF, 0); tick();
    applyStimulus(4'h2, 1, 64'h77, 0, 0, 4'h5, 4'hF);
    pushExpected(4'h2, 64'h77, 0, 4'h5, 4'hF, 0); tick();
    applyIdle(); tick(); tick();

    // Two-cycle stall with a store in M
    applyStimulus(4'h4, 0, 64'h140, 64'h0102030405060708, 0, 4'hF, 4'hF);
    pushExpected(4'h4, 64'h140, 0, 4'hF, 4'hF, 0); tick();
    applyIdle(); m_stall = 1'b1;
    tick(); checkOutput("stall1_w_valid", 64'(w_valid), 64'd0);
    tick(); checkOutput("stall2_w_valid", 64'(w_valid), 64'd0);
    m_stall = 1'b0;
    applyStimulus(4'h5, 0, 64'h140, 0, 0, 4'hF, 4'h6);
    pushExpected(4'h5, 64'h140, 64'h0102030405060708, 4'hF, 4'h6, 0); tick();
    applyIdle(); tick();

    // Stall and bubble together: the store must survive
    applyStimulus(4'h4, 0, 64'h148, 64'h1020304050607080, 0, 4'hF, 4'hF);
    pushExpected(4'h4, 64'h148, 0, 4'hF, 4'hF, 0); tick();
    applyIdle(); m_stall = 1'b1; m_bubble = 1'b1;
    tick(); checkOutput("stallbub_w_valid", 64'(w_valid), 64'd0);
    m_stall = 1'b0; m_bubble = 1'b0;
    applyStimulus(4'h5, 0, 64'h148, 0, 0, 4'hF, 4'h7);
    pushExpected(4'h5, 64'h148, 64'h1020304050607080, 4'hF, 4'h7, 0); tick();
    applyIdle(); tick();

    // Reset while a store sits in M cancels it
    applyStimulus(4'h4, 0, 64'h180, 64'hA5A5A5A5A5A5A5A5, 0, 4'hF, 4'hF);
    pushExpected(4'h4, 64'h180, 0, 4'hF, 4'hF, 0); tick();
    applyIdle(); tick(); tick();
    applyStimulus(4'h4, 0, 64'h180, 64'h5A5A5A5A5A5A5A5A, 0, 4'hF, 4'hF); tick();
    applyIdle();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checkResetState("midreset");
    rst = 1'b0;
    applyStimulus(4'h5, 0, 64'h180, 0, 0, 4'hF, 4'h1);
    pushExpected(4'h5, 64'h180, 64'hA5A5A5A5A5A5A5A5, 4'hF, 4'h1, 0); tick();
    applyIdle(); tick();

    // Address error halts; the following store is squashed
    applyStimulus(4'h5, 0, 64'h3F8, 0, 0, 4'hF, 4'h2);
    pushExpected(4'h5, 64'h3F8, 64'h40, 4'hF, 4'h2, 0); tick();
    applyStimulus(4'h4, 0, 64'h200, 64'h0C0C0C0C0C0C0C0C, 0, 4'hF, 4'hF);
    pushExpected(4'h4, 64'h200, 0, 4'hF, 4'hF, 0); tick();
    applyStimulus(4'h5, 0, 64'h3F9, 0, 0, 4'hF, 4'h4);
    pushExpected(4'h5, 64'h3F9, 0, 4'hF, 4'h4, 2'd2); tick();
    applyStimulus(4'h4, 0, 64'h200, 64'h0D0D0D0D0D0D0D0D, 0, 4'hF, 4'hF); tick();
    checkOutput("halt_set", 64'(halted), 64'd1);
    applyIdle(); tick();
    checkOutput("halted_w_valid", 64'(w_valid), 64'd0);
    checkOutput("halt_sticky", 64'(halted), 64'd1);
    tick();

    // Reset clears halt; memory kept the pre-halt value
    rst = 1'b1; #2 rst = 1'b0;
    checkOutput("halt_cleared", 64'(halted), 64'd0);
    applyStimulus(4'h5, 0, 64'h200, 0, 0, 4'hF, 4'h5);
    pushExpected(4'h5, 64'h200, 64'h0C0C0C0C0C0C0C0C, 4'hF, 4'h5, 0); tick();
    applyIdle(); tick(); tick();

    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
